// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the processor/datapath side and the multdiv control sequencer.
// The master drives start pulses and datapath status; the slave drives datapath controls.
interface multdiv_sequencer_if #(
  parameter int unsigned CNT_W = 6
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             divisor_zero;
  logic             mult_ovf;
  logic             op_latch_en;
  logic             acc_w_en;
  logic             acc_init;
  logic             op_is_div;
  logic [CNT_W-1:0] step;
  logic             busy;
  logic             result_rdy;
  logic             exception;

  modport master (
    output ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf,
    input  op_latch_en, acc_w_en, acc_init, op_is_div, step, busy, result_rdy, exception
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf,
    output op_latch_en, acc_w_en, acc_init, op_is_div, step, busy, result_rdy, exception
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multdiv datapath: latches operands on a start pulse, runs a
// fixed number of accumulator steps, then pulses result_rdy with an exception flag.
module multdiv_sequencer #(
  parameter int unsigned MULT_STEPS = 16,
  parameter int unsigned DIV_STEPS  = 32,
  parameter int unsigned CNT_W      = 6
) (
  input logic                  clk,
  input logic                  clr,
  multdiv_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] MultLast = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DivLast  = CNT_W'(DIV_STEPS - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_step, w_step_nxt;
  logic             r_op_is_div, w_op_is_div_nxt;
  logic             r_dz_flag, w_dz_flag_nxt;
  logic             w_start, w_last_step;
  logic             w_op_latch_en, w_acc_w_en, w_acc_init, w_busy, w_result_rdy, w_exception;

  assign w_start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_last_step = (r_step == (r_op_is_div ? DivLast : MultLast));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= StIdle;
      r_step      <= '0;
      r_op_is_div <= 1'b0;
      r_dz_flag   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_op_is_div <= w_op_is_div_nxt;
      r_dz_flag   <= w_dz_flag_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_step_nxt      = r_step;
    w_op_is_div_nxt = r_op_is_div;
    w_dz_flag_nxt   = r_dz_flag;
    w_op_latch_en   = 1'b0;
    w_acc_w_en      = 1'b0;
    w_acc_init      = 1'b0;
    w_busy          = 1'b0;
    w_result_rdy    = 1'b0;
    w_exception     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_op_latch_en = w_start;
        if (w_start) begin
          w_state_nxt     = StInit;
          w_op_is_div_nxt = bus.ctrl_DIV & ~bus.ctrl_MULT;
        end
      end
      StInit: begin
        w_busy        = 1'b1;
        w_acc_w_en    = 1'b1;
        w_acc_init    = 1'b1;
        w_step_nxt    = '0;
        w_dz_flag_nxt = r_op_is_div & bus.divisor_zero;
        // Divide-by-zero has nothing to iterate; go straight to reporting.
        w_state_nxt   = w_dz_flag_nxt ? StDone : StRun;
      end
      StRun: begin
        w_busy     = 1'b1;
        w_acc_w_en = 1'b1;
        if (w_last_step) begin
          w_state_nxt = StDone;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step + 1'b1;
        end
      end
      StDone: begin
        w_busy       = 1'b1;
        w_result_rdy = 1'b1;
        w_exception  = r_op_is_div ? r_dz_flag : bus.mult_ovf;
        w_state_nxt  = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign bus.op_latch_en = w_op_latch_en;
  assign bus.acc_w_en    = w_acc_w_en;
  assign bus.acc_init    = w_acc_init;
  assign bus.op_is_div   = r_op_is_div;
  assign bus.step        = r_step;
  assign bus.busy        = w_busy;
  assign bus.result_rdy  = w_result_rdy;
  assign bus.exception   = w_exception;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: cycle-by-cycle output vectors for each scenario.
module tb_multdiv_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multdiv_sequencer_if #(.CNT_W(6)) bus ();

  multdiv_sequencer #(
    .MULT_STEPS(16),
    .DIV_STEPS (32),
    .CNT_W     (6)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  // {op_latch_en, acc_w_en, acc_init, op_is_div, busy, result_rdy, exception}
  logic [6:0] obs_vec, exp_v;
  logic [5:0] exp_s;

  assign obs_vec = {bus.op_latch_en, bus.acc_w_en, bus.acc_init, bus.op_is_div,
                    bus.busy, bus.result_rdy, bus.exception};

  // Expected outputs u cycles after a start pulse (u = 0 is the pulse cycle).
  function automatic logic [6:0] exp_vec(int u, int n, bit dz, bit exc_v, bit isdiv,
                                         bit prev_div);
    int  done_u;
    logic ole, aw, ai, od, bsy, rdy, exc;
    done_u = dz ? 2 : n + 2;
    ole = (u == 0);
    aw  = dz ? (u == 1) : (u >= 1 && u <= n + 1);
    ai  = (u == 1);
    od  = (u >= 1) ? isdiv : prev_div;
    bsy = (u >= 1 && u <= done_u);
    rdy = (u == done_u);
    exc = rdy & exc_v;
    return {ole, aw, ai, od, bsy, rdy, exc};
  endfunction

  function automatic logic [5:0] exp_step(int u, int n, bit dz);
    if (!dz && u >= 2 && u <= n + 1) return 6'(u - 2);
    return 6'd0;
  endfunction

  task automatic drive(bit m, bit d, bit dzr, bit ovf, bit c);
    bus.ctrl_MULT    = m;
    bus.ctrl_DIV     = d;
    bus.divisor_zero = dzr;
    bus.mult_ovf     = ovf;
    clr              = c;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    n_vec++;
    if (obs_vec !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected %b", obs_vec, 7'b0);
    end
    n_vec++;
    if (bus.step !== 6'd0) begin
      n_err++;
      $display("FAIL reset_step: got %0d expected 0", bus.step);
    end
  endtask

  task automatic test_mult();
    for (int t = 0; t <= 21; t++) begin
      @(posedge clk);
      #1 drive(t == 0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      exp_v = exp_vec(t, 16, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_s = exp_step(t, 16, 1'b0);
      n_vec++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL mult_vec t=%0d: got %b expected %b", t, obs_vec, exp_v);
      end
      n_vec++;
      if (bus.step !== exp_s) begin
        n_err++;
        $display("FAIL mult_step t=%0d: got %0d expected %0d", t, bus.step, exp_s);
      end
    end
  endtask

  task automatic test_div();
    int aw_cnt = 0;
    for (int t = 0; t <= 37; t++) begin
      @(posedge clk);
      #1 drive(1'b0, t == 0, 1'b0, 1'b0, 1'b0);
      #3;
      if (bus.acc_w_en === 1'b1) aw_cnt++;
      exp_v = exp_vec(t, 32, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_s = exp_step(t, 32, 1'b0);
      n_vec++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL div_vec t=%0d: got %b expected %b", t, obs_vec, exp_v);
      end
      n_vec++;
      if (bus.step !== exp_s) begin
        n_err++;
        $display("FAIL div_step t=%0d: got %0d expected %0d", t, bus.step, exp_s);
      end
    end
    n_vec++;
    if (aw_cnt != 33) begin
      n_err++;
      $display("FAIL div_acc_w_en_cycles: got %0d expected 33", aw_cnt);
    end
  endtask

  task automatic test_div_by_zero();
    for (int t = 0; t <= 5; t++) begin
      @(posedge clk);
      #1 drive(1'b0, t == 0, 1'b1, 1'b0, 1'b0);
      #3;
      exp_v = exp_vec(t, 32, 1'b1, 1'b1, 1'b1, 1'b1);
      exp_s = exp_step(t, 32, 1'b1);
      n_vec++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL divzero_vec t=%0d: got %b expected %b", t, obs_vec, exp_v);
      end
      n_vec++;
      if (bus.step !== exp_s) begin
        n_err++;
        $display("FAIL divzero_step t=%0d: got %0d expected %0d", t, bus.step, exp_s);
      end
    end
  endtask

  task automatic test_both_and_ignored();
    for (int t = 0; t <= 24; t++) begin
      @(posedge clk);
      #1 drive(t == 0, t == 0 || t == 5, 1'b0, 1'b0, 1'b0);
      #3;
      exp_v = exp_vec(t, 16, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_s = exp_step(t, 16, 1'b0);
      n_vec++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL both_vec t=%0d: got %b expected %b", t, obs_vec, exp_v);
      end
      n_vec++;
      if (bus.step !== exp_s) begin
        n_err++;
        $display("FAIL both_step t=%0d: got %0d expected %0d", t, bus.step, exp_s);
      end
    end
  endtask

  task automatic test_clr_mid_op();
    for (int t = 0; t <= 31; t++) begin
      @(posedge clk);
      #1 drive(t == 10, t == 0, 1'b0, 1'b0, t == 8);
      #3;
      if (t <= 8) begin
        exp_v = exp_vec(t, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_s = exp_step(t, 32, 1'b0);
      end else if (t == 9) begin
        exp_v = 7'b0;
        exp_s = 6'd0;
      end else begin
        exp_v = exp_vec(t - 10, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_s = exp_step(t - 10, 16, 1'b0);
      end
      n_vec++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL clr_vec t=%0d: got %b expected %b", t, obs_vec, exp_v);
      end
      n_vec++;
      if (bus.step !== exp_s) begin
        n_err++;
        $display("FAIL clr_step t=%0d: got %0d expected %0d", t, bus.step, exp_s);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t <= 40; t++) begin
      @(posedge clk);
      #1 drive(t == 0 || t == 19, 1'b0, 1'b0, t == 18, 1'b0);
      #3;
      if (t < 19) begin
        exp_v = exp_vec(t, 16, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_s = exp_step(t, 16, 1'b0);
      end else begin
        exp_v = exp_vec(t - 19, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_s = exp_step(t - 19, 16, 1'b0);
      end
      n_vec++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL b2b_vec t=%0d: got %b expected %b", t, obs_vec, exp_v);
      end
      n_vec++;
      if (bus.step !== exp_s) begin
        n_err++;
        $display("FAIL b2b_step t=%0d: got %0d expected %0d", t, bus.step, exp_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_both_and_ignored();
    test_clr_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
